// File: rtl/maze_probe.sv
// maze_probe: samples the maze wall ROM at 20 points around a sprite's bounding box and returns four 5-bit wall masks.
// Optional macro MAZE_PROBE_TUNNEL_EN: out-of-range x inside the tunnel band reads as open.
module maze_probe #(
    parameter int MAZE_W       = 400,
    parameter int MAZE_H       = 448,
    parameter int TILE_SHIFT   = 3,
    parameter int COLS         = 50,
    parameter int TUNNEL_Y_MIN = 195,
    parameter int TUNNEL_Y_MAX = 223
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [9:0]  posX,
    input  logic [9:0]  posY,
    input  logic [9:0]  size,
    output logic [11:0] rom_addr,
    input  logic        rom_data,
    output logic [4:0]  mapL,
    output logic [4:0]  mapR,
    output logic [4:0]  mapB,
    output logic [4:0]  mapT,
    output logic        busy,
    output logic        done
);

`ifdef MAZE_PROBE_TUNNEL_EN
    localparam bit TUNNEL_EN = 1'b1;
`else
    localparam bit TUNNEL_EN = 1'b0;
`endif

    localparam logic [11:0] MAZE_W12 = 12'(MAZE_W);
    localparam logic [11:0] MAZE_H12 = 12'(MAZE_H);
    localparam logic [11:0] TY_MIN12 = 12'(TUNNEL_Y_MIN);
    localparam logic [11:0] TY_MAX12 = 12'(TUNNEL_Y_MAX);
    localparam logic [11:0] COLS12   = 12'(COLS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    logic [9:0]  r_px, r_py, r_sz;
    logic [1:0]  r_side;
    logic [2:0]  r_k;
    logic        r_v0, r_f0, r_fv0;
    logic        r_v1, r_f1, r_fv1;
    logic [19:0] r_acc;
    logic [9:0]  w_px, w_py, w_sz;
    logic [13:0] w_probe;

    // Returns {forced, forced_value, address}; the row multiply is a shift-add over the set bits of COLS.
    function automatic logic [13:0] probe_slot(
        input logic [9:0] px,
        input logic [9:0] py,
        input logic [9:0] sz,
        input logic [1:0] side,
        input logic [2:0] k
    );
        logic signed [11:0] s, h, off, cx, cy, x, y;
        logic               x_bad, y_bad, band, fval;
        logic [11:0]        row, col, addr;
        s  = $signed({2'b00, sz});
        h  = $signed({3'b000, sz[9:1]});
        cx = $signed({2'b00, px});
        cy = $signed({2'b00, py});
        case (k)
            3'd0:    off = -s;
            3'd1:    off = -h;
            3'd2:    off = 12'sd0;
            3'd3:    off = h;
            default: off = s;
        endcase
        case (side)
            2'd0: begin x = cx - s - 12'sd1; y = cy + off;        end
            2'd1: begin x = cx + s + 12'sd1; y = cy + off;        end
            2'd2: begin x = cx + off;        y = cy + s + 12'sd1; end
            default: begin x = cx + off;     y = cy - s - 12'sd1; end
        endcase
        x_bad = x[11] || ($unsigned(x) >= MAZE_W12);
        y_bad = y[11] || ($unsigned(y) >= MAZE_H12);
        band  = ($unsigned(y) >= TY_MIN12) && ($unsigned(y) <= TY_MAX12);
        fval  = !(TUNNEL_EN && x_bad && !y_bad && band);
        row   = $unsigned(y) >> TILE_SHIFT;
        col   = $unsigned(x) >> TILE_SHIFT;
        addr  = 12'd0;
        for (int b = 0; b < 12; b++) begin
            if (COLS12[b]) addr = addr + (row << b);
            else           addr = addr;
        end
        if (x_bad || y_bad) addr = 12'd0;
        else                addr = addr + col;
        return {x_bad || y_bad, fval, addr};
    endfunction

    // Slot 0 is issued on the start edge itself, so it must see the live inputs.
    always_comb begin
        w_px = r_px;
        w_py = r_py;
        w_sz = r_sz;
        if (r_state == S_IDLE) begin
            w_px = posX;
            w_py = posY;
            w_sz = size;
        end else begin
            w_px = r_px;
            w_py = r_py;
            w_sz = r_sz;
        end
        w_probe = probe_slot(w_px, w_py, w_sz, r_side, r_k);
    end

    // Scan FSM, read pipeline and mask commit.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_px     <= 10'd0;
            r_py     <= 10'd0;
            r_sz     <= 10'd0;
            r_side   <= 2'd0;
            r_k      <= 3'd0;
            r_v0     <= 1'b0;
            r_f0     <= 1'b0;
            r_fv0    <= 1'b0;
            r_v1     <= 1'b0;
            r_f1     <= 1'b0;
            r_fv1    <= 1'b0;
            r_acc    <= 20'd0;
            rom_addr <= 12'd0;
            mapL     <= 5'd0;
            mapR     <= 5'd0;
            mapB     <= 5'd0;
            mapT     <= 5'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_v1  <= r_v0;
            r_f1  <= r_f0;
            r_fv1 <= r_fv0;
            if (r_v1) r_acc <= {(r_f1 ? r_fv1 : rom_data), r_acc[19:1]};
            else      r_acc <= r_acc;
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_px     <= posX;
                        r_py     <= posY;
                        r_sz     <= size;
                        busy     <= 1'b1;
                        rom_addr <= w_probe[11:0];
                        r_f0     <= w_probe[13];
                        r_fv0    <= w_probe[12];
                        r_v0     <= 1'b1;
                        r_side   <= 2'd0;
                        r_k      <= 3'd1;
                        r_state  <= S_SCAN;
                    end else begin
                        rom_addr <= 12'd0;
                        r_v0     <= 1'b0;
                    end
                end
                S_SCAN: begin
                    rom_addr <= w_probe[11:0];
                    r_f0     <= w_probe[13];
                    r_fv0    <= w_probe[12];
                    r_v0     <= 1'b1;
                    if (r_side == 2'd3 && r_k == 3'd4) begin
                        r_side  <= 2'd0;
                        r_k     <= 3'd0;
                        r_state <= S_DRAIN;
                    end else if (r_k == 3'd4) begin
                        r_side <= r_side + 2'd1;
                        r_k    <= 3'd0;
                    end else begin
                        r_k <= r_k + 3'd1;
                    end
                end
                S_DRAIN: begin
                    rom_addr <= 12'd0;
                    r_v0     <= 1'b0;
                    if (r_k == 3'd1) begin
                        r_k     <= 3'd0;
                        r_state <= S_DONE;
                    end else begin
                        r_k <= r_k + 3'd1;
                    end
                end
                default: begin
                    rom_addr <= 12'd0;
                    r_v0     <= 1'b0;
                    mapL     <= r_acc[4:0];
                    mapR     <= r_acc[9:5];
                    mapB     <= r_acc[14:10];
                    mapT     <= r_acc[19:15];
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maze_probe.sv
// Self-checking bench for maze_probe: ROM model, behavioural probe model, directed and randomized scans.
module tb_maze_probe;

`ifdef MAZE_PROBE_TUNNEL_EN
    localparam bit TUNNEL = 1'b1;
`else
    localparam bit TUNNEL = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [9:0]  posX, posY, size;
    logic [11:0] rom_addr;
    logic        rom_data = 1'b0;
    logic [4:0]  mapL, mapR, mapB, mapT;
    logic        busy, done;

    int checks = 0;
    int errors = 0;
    logic        mem [0:4095];
    logic [19:0] shown;

    maze_probe dut (
        .Clk(Clk), .Reset(Reset), .start(start),
        .posX(posX), .posY(posY), .size(size),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .mapL(mapL), .mapR(mapR), .mapB(mapB), .mapT(mapT),
        .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) rom_data <= mem[rom_addr];

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic fill_mem(input int mode);
        for (int i = 0; i < 4096; i++) begin
            if (mode == 0)      mem[i] = 1'b0;
            else if (mode == 1) mem[i] = 1'b1;
            else                mem[i] = ($urandom_range(0, 3) == 0);
        end
    endtask

    function automatic void probe_xy(input int px, input int py, input int sz, input int slot,
                                     output int x, output int y);
        int k, side, h, off;
        k = slot % 5;
        side = slot / 5;
        h = sz / 2;
        case (k)
            0: off = -sz;
            1: off = -h;
            2: off = 0;
            3: off = h;
            default: off = sz;
        endcase
        case (side)
            0: begin x = px - sz - 1; y = py + off; end
            1: begin x = px + sz + 1; y = py + off; end
            2: begin x = px + off; y = py + sz + 1; end
            default: begin x = px + off; y = py - sz - 1; end
        endcase
    endfunction

    function automatic bit in_maze(input int x, input int y);
        return x >= 0 && x < 400 && y >= 0 && y < 448;
    endfunction

    function automatic int ref_addr(input int x, input int y);
        return in_maze(x, y) ? (y / 8) * 50 + x / 8 : 0;
    endfunction

    function automatic bit ref_bit(input int x, input int y);
        if (y < 0 || y >= 448) return 1'b1;
        if (x < 0 || x >= 400) return (TUNNEL && y >= 195 && y <= 223) ? 1'b0 : 1'b1;
        return mem[(y / 8) * 50 + x / 8];
    endfunction

    function automatic logic [19:0] ref_masks(input int px, input int py, input int sz);
        logic [19:0] m;
        int x, y;
        m = 20'd0;
        for (int s = 0; s < 20; s++) begin
            probe_xy(px, py, sz, s, x, y);
            m[s] = ref_bit(x, y);
        end
        return m;
    endfunction

    // Full scan from an idle DUT; leaves the bench 1 time unit after the done edge.
    task automatic do_scan(input int px, input int py, input int sz, output logic [11:0] first_addr);
        logic [19:0] exp;
        int x, y;
        exp = ref_masks(px, py, sz);
        posX = px[9:0]; posY = py[9:0]; size = sz[9:0];
        start = 1'b1;
        tick;
        start = 1'b0;
        first_addr = 12'd0;
        for (int n = 0; n <= 22; n++) begin
            if (n <= 19) begin
                probe_xy(px, py, sz, n, x, y);
                if (n == 0) first_addr = rom_addr;
                checks++;
                if (rom_addr !== 12'(ref_addr(x, y))) begin
                    errors++;
                    $display("FAIL rom_addr slot %0d: got %0d expected %0d", n, rom_addr, ref_addr(x, y));
                end
            end
            checks++;
            if (busy !== (n < 22)) begin
                errors++;
                $display("FAIL busy cycle %0d: got %b expected %b", n, busy, (n < 22));
            end
            checks++;
            if (done !== (n == 22)) begin
                errors++;
                $display("FAIL done cycle %0d: got %b expected %b", n, done, (n == 22));
            end
            if (n == 11) begin
                checks++;
                if ({mapT, mapB, mapR, mapL} !== shown) begin
                    errors++;
                    $display("FAIL mask_hold: got %h expected %h", {mapT, mapB, mapR, mapL}, shown);
                end
            end
            if (n < 22) tick;
        end
        checks++;
        if ({mapT, mapB, mapR, mapL} !== exp) begin
            errors++;
            $display("FAIL masks (%0d,%0d,%0d): got %h expected %h", px, py, sz, {mapT, mapB, mapR, mapL}, exp);
        end
        shown = exp;
    endtask

    task automatic test_reset;
        Reset = 1'b1; start = 1'b0;
        repeat (3) tick;
        checks++;
        if ({mapT, mapB, mapR, mapL, busy, done, rom_addr} !== 34'd0) begin
            errors++;
            $display("FAIL reset_outputs: got masks=%h busy=%b done=%b addr=%0d expected all 0",
                     {mapT, mapB, mapR, mapL}, busy, done, rom_addr);
        end
        Reset = 1'b0;
        shown = 20'd0;
        tick;
    endtask

    task automatic test_zero_rom;
        logic [11:0] fa;
        fill_mem(0);
        do_scan(144, 165, 13, fa);
        checks++;
        if (fa !== 12'd966) begin
            errors++;
            $display("FAIL first_addr: got %0d expected 966", fa);
        end
        checks++;
        if ({mapT, mapB, mapR, mapL} !== 20'd0) begin
            errors++;
            $display("FAIL zero_rom_masks: got %h expected 0", {mapT, mapB, mapR, mapL});
        end
    endtask

    task automatic test_ones_rom;
        logic [11:0] fa;
        fill_mem(1);
        do_scan(144, 165, 13, fa);
        checks++;
        if ({mapT, mapB, mapR, mapL} !== 20'hFFFFF) begin
            errors++;
            $display("FAIL ones_rom_masks: got %h expected fffff", {mapT, mapB, mapR, mapL});
        end
    endtask

    task automatic test_single_wall;
        logic [11:0] fa;
        fill_mem(0);
        mem[1016] = 1'b1;
        do_scan(144, 165, 13, fa);
        checks++;
        if (mapL !== 5'b00100 || {mapT, mapB, mapR} !== 15'd0) begin
            errors++;
            $display("FAIL single_wall: got L=%b R=%b B=%b T=%b expected L=00100 others 0", mapL, mapR, mapB, mapT);
        end
    endtask

    task automatic test_tunnel;
        logic [11:0] fa;
        logic [4:0]  exp_l;
        fill_mem(0);
        exp_l = TUNNEL ? 5'b00000 : 5'b11111;
        do_scan(10, 210, 13, fa);
        checks++;
        if (mapL !== exp_l || mapR !== 5'b00000) begin
            errors++;
            $display("FAIL tunnel: got L=%b R=%b expected L=%b R=00000", mapL, mapR, exp_l);
        end
    endtask

    task automatic test_back_to_back;
        logic [11:0] fa;
        int px, py, sz;
        for (int t = 0; t < 10; t++) begin
            fill_mem(2);
            px = int'($urandom_range(0, 1023));
            py = (t % 3 == 0) ? int'($urandom_range(190, 228)) : int'($urandom_range(0, 1023));
            sz = (t % 4 == 3) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 40));
            if (t % 3 == 0) px = int'($urandom_range(0, 30));
            do_scan(px, py, sz, fa);
        end
    endtask

    task automatic test_start_ignored;
        logic [19:0] exp;
        int ndone, done_at;
        fill_mem(2);
        exp = ref_masks(200, 100, 20);
        posX = 10'd200; posY = 10'd100; size = 10'd20;
        start = 1'b1;
        tick;
        start = 1'b0;
        ndone = 0; done_at = -1;
        for (int n = 0; n < 50; n++) begin
            if (n == 4) begin
                posX = 10'd50; posY = 10'd50; size = 10'd5;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                ndone++;
                if (done_at < 0) done_at = n;
            end
            tick;
        end
        checks++;
        if (ndone != 1 || done_at != 22) begin
            errors++;
            $display("FAIL start_ignored: got %0d done pulses (first at %0d) expected 1 at 22", ndone, done_at);
        end
        checks++;
        if ({mapT, mapB, mapR, mapL} !== exp) begin
            errors++;
            $display("FAIL start_ignored_masks: got %h expected %h", {mapT, mapB, mapR, mapL}, exp);
        end
        shown = exp;
    endtask

    task automatic test_reset_abort;
        int ndone;
        fill_mem(1);
        posX = 10'd144; posY = 10'd165; size = 10'd13;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (9) tick;
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rom_addr !== 12'd0 || {mapT, mapB, mapR, mapL} !== 20'd0) begin
            errors++;
            $display("FAIL reset_abort: got busy=%b done=%b addr=%0d masks=%h expected all 0",
                     busy, done, rom_addr, {mapT, mapB, mapR, mapL});
        end
        shown = 20'd0;
        ndone = 0;
        for (int n = 0; n < 30; n++) begin
            if (done === 1'b1) ndone++;
            tick;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL reset_abort_done: got %0d done pulses expected 0", ndone);
        end
    endtask

    task automatic test_reset_with_start;
        logic [11:0] fa;
        posX = 10'd144; posY = 10'd165; size = 10'd13;
        Reset = 1'b1; start = 1'b1;
        tick;
        Reset = 1'b0; start = 1'b0;
        repeat (3) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reset_with_start: got busy=%b done=%b expected 0 0", busy, done);
            end
            tick;
        end
        fill_mem(2);
        do_scan(300, 400, 30, fa);
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0;
        posX = 10'd0; posY = 10'd0; size = 10'd0;
        shown = 20'd0;
        fill_mem(0);
        test_reset;
        test_zero_rom;
        test_ones_rom;
        test_single_wall;
        test_tunnel;
        test_back_to_back;
        test_start_ignored;
        test_reset_abort;
        test_reset_with_start;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
